// File: rtl/rvv_vd_collector.sv
// Vector write-back collector: merges per-lane ALU results into the old vd image under vl/v0 policy.
// Lane results visible in wb_data one cycle later; wb_valid/wb_data held in WRITE until wb_ready.
module rvv_vd_collector #(
  parameter int VLEN     = 128,
  parameter int NB_LANES = 1,
  localparam int LANES   = 1 << NB_LANES
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [VLEN-1:0]       old_vd,
  input  logic [VLEN-1:0]       v0_mask,
  input  logic                  vm,
  input  logic [2:0]            vsew,
  input  logic [10:0]           vl,
  input  logic                  instr_mask,
  input  logic [64*LANES-1:0]   vd_in,
  input  logic [10*LANES-1:0]   regi,
  input  logic [LANES-1:0]      res,
  input  logic                  alu_done,
  input  logic                  wb_ready,
  output logic                  busy,
  output logic                  wb_valid,
  output logic [VLEN-1:0]       wb_data,
  output logic [10:0]           wb_count,
  output logic                  err
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WRITE} state_t;

  state_t            state_q, state_nxt;
  logic [VLEN-1:0]   buf_q, buf_nxt;
  logic [VLEN-1:0]   v0_q;
  logic              vm_q;
  logic [1:0]        vsew_q;
  logic [10:0]       vl_q;
  logic              imask_q;
  logic [10:0]       cnt_q, cnt_nxt;
  logic              err_q, err_hit;

  logic [VLEN-1:0]   ones, wmask, wdat, v0_sh;
  logic [9:0]        idx;
  logic [11:0]       limit, cnt_sum;
  int                sew_bits, nwr, sh;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE:    if (start) state_nxt = vsew[2] ? S_WRITE : S_COLLECT;
      S_COLLECT: if (alu_done) state_nxt = S_WRITE;
      S_WRITE:   if (wb_ready) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Lanes are merged in ascending order so the highest lane wins on an index collision.
  always_comb begin
    buf_nxt  = buf_q;
    err_hit  = 1'b0;
    nwr      = 0;
    idx      = '0;
    v0_sh    = '0;
    wmask    = '0;
    wdat     = '0;
    sh       = 0;
    sew_bits = 8 << vsew_q;
    limit    = imask_q ? 12'(VLEN) : 12'(VLEN >> (int'(vsew_q) + 3));
    case (vsew_q)
      2'd0:    ones = VLEN'(64'h0000_0000_0000_00FF);
      2'd1:    ones = VLEN'(64'h0000_0000_0000_FFFF);
      2'd2:    ones = VLEN'(64'h0000_0000_FFFF_FFFF);
      default: ones = VLEN'(64'hFFFF_FFFF_FFFF_FFFF);
    endcase
    for (int i = 0; i < LANES; i++) begin
      idx   = regi[10*i +: 10];
      v0_sh = v0_q >> idx;
      if (res[i]) begin
        if ({2'b00, idx} >= limit) begin
          err_hit = 1'b1;
        end else if ({1'b0, idx} < vl_q && (vm_q || v0_sh[0])) begin
          nwr = nwr + 1;
          if (imask_q) begin
            wmask = VLEN'(1) << idx;
            wdat  = VLEN'(vd_in[64*i]) << idx;
          end else begin
            sh    = int'(idx) * sew_bits;
            wmask = ones << sh;
            wdat  = (VLEN'(vd_in[64*i +: 64]) & ones) << sh;
          end
          buf_nxt = (buf_nxt & ~wmask) | wdat;
        end
      end
    end
    cnt_sum = {1'b0, cnt_q} + 12'(nwr);
    cnt_nxt = (cnt_sum > 12'd2047) ? 11'd2047 : cnt_sum[10:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      buf_q   <= '0;
      v0_q    <= '0;
      vm_q    <= 1'b0;
      vsew_q  <= '0;
      vl_q    <= '0;
      imask_q <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          buf_q   <= old_vd;
          v0_q    <= v0_mask;
          vm_q    <= vm;
          vsew_q  <= vsew[1:0];
          vl_q    <= vl;
          imask_q <= instr_mask;
          cnt_q   <= '0;
          err_q   <= vsew[2];
        end
        S_COLLECT: begin
          buf_q <= buf_nxt;
          cnt_q <= cnt_nxt;
          if (err_hit) err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign wb_valid = (state_q == S_WRITE);
  assign wb_data  = buf_q;
  assign wb_count = cnt_q;
  assign err      = err_q;

endmodule

// File: tb/tb_rvv_vd_collector.sv
// Directed bench for rvv_vd_collector (VLEN=128, two lanes).
module tb_rvv_vd_collector;

  logic         clk = 1'b0;
  logic         resetn;
  logic         start;
  logic [127:0] old_vd, v0_mask;
  logic         vm;
  logic [2:0]   vsew;
  logic [10:0]  vl;
  logic         instr_mask;
  logic [127:0] vd_in;
  logic [19:0]  regi;
  logic [1:0]   res;
  logic         alu_done;
  logic         wb_ready;
  logic         busy, wb_valid, err;
  logic [127:0] wb_data;
  logic [10:0]  wb_count;

  int total = 0;
  int passed = 0;
  logic [127:0] e, held;

  rvv_vd_collector #(.VLEN(128), .NB_LANES(1)) dut (
    .clk(clk), .resetn(resetn), .start(start), .old_vd(old_vd), .v0_mask(v0_mask),
    .vm(vm), .vsew(vsew), .vl(vl), .instr_mask(instr_mask), .vd_in(vd_in), .regi(regi),
    .res(res), .alu_done(alu_done), .wb_ready(wb_ready), .busy(busy), .wb_valid(wb_valid),
    .wb_data(wb_data), .wb_count(wb_count), .err(err)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic do_start(input logic [2:0] s, input logic [10:0] l, input logic m,
                          input logic [127:0] v0, input logic [127:0] old, input logic im);
    vsew = s; vl = l; vm = m; v0_mask = v0; old_vd = old; instr_mask = im;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic send(input logic [9:0] i0, input logic [63:0] d0, input logic e0,
                      input logic [9:0] i1, input logic [63:0] d1, input logic e1,
                      input logic done);
    regi = {i1, i0}; vd_in = {d1, d0}; res = {e1, e0}; alu_done = done;
    cyc();
    res = 2'b00; alu_done = 1'b0;
  endtask

  task automatic seq8();
    for (int k = 0; k < 8; k++)
      send(10'(2*k), 64'(8'hA0 + 2*k), 1'b1, 10'(2*k+1), 64'(8'hA0 + 2*k + 1), 1'b1, k == 7);
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; old_vd = '0; v0_mask = '0; vm = 1'b1; vsew = '0; vl = '0;
    instr_mask = 1'b0; vd_in = '0; regi = '0; res = '0; alu_done = 1'b0; wb_ready = 1'b1;
    cyc(); cyc();
    chk("rst_busy", busy, 0);
    chk("rst_valid", wb_valid, 0);
    chk("rst_data", wb_data, 0);
    chk("rst_count", wb_count, 0);
    chk("rst_err", err, 0);
    resetn = 1'b1;
    cyc();

    // SEW=8, full vl, unmasked
    do_start(3'd0, 11'd16, 1'b1, '0, '0, 1'b0);
    chk("t1_busy", busy, 1);
    chk("t1_valid_early", wb_valid, 0);
    seq8();
    for (int n = 0; n < 16; n++) e[n*8 +: 8] = 8'(8'hA0 + n);
    chk("t1_valid", wb_valid, 1);
    chk("t1_data", wb_data, e);
    chk("t1_count", wb_count, 16);
    chk("t1_err", err, 0);
    cyc();
    chk("t1_idle_valid", wb_valid, 0);
    chk("t1_idle_busy", busy, 0);
    chk("t1_hold_data", wb_data, e);
    chk("t1_hold_count", wb_count, 16);

    // SEW=8, vl=10 tail undisturbed
    do_start(3'd0, 11'd10, 1'b1, '0, {128{1'b1}}, 1'b0);
    seq8();
    e = {128{1'b1}};
    for (int n = 0; n < 10; n++) e[n*8 +: 8] = 8'(8'hA0 + n);
    chk("t2_data", wb_data, e);
    chk("t2_count", wb_count, 10);
    cyc();

    // SEW=32 masked by v0=0x5
    do_start(3'd2, 11'd4, 1'b0, 128'h5, '0, 1'b0);
    send(10'd0, 64'h1111_1111, 1'b1, 10'd1, 64'h2222_2222, 1'b1, 1'b0);
    chk("t3_partial", wb_data, 128'h1111_1111);
    send(10'd2, 64'h3333_3333, 1'b1, 10'd3, 64'h4444_4444, 1'b1, 1'b1);
    chk("t3_data", wb_data, {32'h0, 32'h3333_3333, 32'h0, 32'h1111_1111});
    chk("t3_count", wb_count, 2);
    cyc();

    // mask-producing op: only lane bit 0 lands at bit idx
    do_start(3'd2, 11'd4, 1'b1, '0, {128{1'b1}}, 1'b1);
    send(10'd0, 64'hFFFF_FFFF, 1'b1, 10'd1, 64'hFFFF_FFFE, 1'b1, 1'b0);
    send(10'd2, 64'h3, 1'b1, 10'd3, 64'h2, 1'b1, 1'b1);
    chk("t4_data", wb_data, {{124{1'b1}}, 4'b0101});
    chk("t4_count", wb_count, 4);
    cyc();

    // SEW=16: out-of-range idx, same-idx collision, write backpressure
    wb_ready = 1'b0;
    do_start(3'd1, 11'd16, 1'b1, '0, '0, 1'b0);
    send(10'd8, 64'h9999, 1'b1, 10'd2, 64'h2222, 1'b1, 1'b0);
    chk("t5_err", err, 1);
    chk("t5_oor_nowrite", wb_data, 128'h2222_0000_0000);
    send(10'd3, 64'hAAAA, 1'b1, 10'd3, 64'hBBBB, 1'b1, 1'b1);
    held = 128'hBBBB_2222_0000_0000;
    chk("t5_collide", wb_data, held);
    chk("t5_count", wb_count, 3);
    for (int c = 0; c < 3; c++) begin
      chk("t5_stall_valid", wb_valid, 1);
      chk("t5_stall_data", wb_data, held);
      if (c == 1) do_start(3'd0, 11'd16, 1'b1, '0, {128{1'b1}}, 1'b0);
      else cyc();
    end
    chk("t5_start_ignored", wb_data, held);
    chk("t5_err_kept", err, 1);
    wb_ready = 1'b1;
    cyc();
    chk("t5_release", wb_valid, 0);
    chk("t5_idle_err", err, 1);

    // illegal vsew goes straight to WRITE with err
    do_start(3'd4, 11'd16, 1'b1, '0, 128'h1234, 1'b0);
    chk("t6_valid", wb_valid, 1);
    chk("t6_err", err, 1);
    chk("t6_data", wb_data, 128'h1234);
    chk("t6_count", wb_count, 0);
    cyc();

    // async reset mid-COLLECT
    do_start(3'd0, 11'd16, 1'b1, '0, {128{1'b1}}, 1'b0);
    chk("t7_err_cleared", err, 0);
    send(10'd0, 64'h55, 1'b1, 10'd1, 64'h66, 1'b1, 1'b0);
    resetn = 1'b0;
    #1;
    chk("t7_busy", busy, 0);
    chk("t7_valid", wb_valid, 0);
    chk("t7_data", wb_data, 0);
    chk("t7_count", wb_count, 0);
    cyc();
    resetn = 1'b1;
    cyc();
    do_start(3'd0, 11'd16, 1'b1, '0, '0, 1'b0);
    seq8();
    for (int n = 0; n < 16; n++) e[n*8 +: 8] = 8'(8'hA0 + n);
    chk("t7_after_valid", wb_valid, 1);
    chk("t7_after_data", wb_data, e);
    chk("t7_after_count", wb_count, 16);
    cyc();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
